// File: rtl/meter_ctrl.sv
// meter_ctrl: sequencing controller for the parking-meter countdown.
//   Arbitrates the coin buttons and preset switches into at most one action per
//   cycle. Generates half-second and one-second ticks from clk. Holds the
//   saturating remaining time. Drives mode and the display-blink enable.
// Ports:
//   clk, clr_n          system clock, async active-low reset
//   pulse_btn{u,l,r,d}  one-cycle add requests (30/120/180/300 s)
//   sw0, sw1            level presets (15 s / 185 s) while high
//   time_out[13:0]      remaining seconds (registered)
//   disp_on             display enable, 0 = blank (registered)
//   mode[1:0]           00 EXPIRED, 01 LOW, 10 RUN (registered)
module meter_ctrl #(
  parameter int HALF_SEC_CYCLES = 50_000_000,
  parameter int MAX_TIME        = 9999,
  parameter int LOW_THRESH      = 200
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        pulse_btnu,
  input  logic        pulse_btnl,
  input  logic        pulse_btnr,
  input  logic        pulse_btnd,
  input  logic        sw0,
  input  logic        sw1,
  output logic [13:0] time_out,
  output logic        disp_on,
  output logic [1:0]  mode
);

  localparam int CW = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_SEC_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_EXPIRED = 2'b00,
    MODE_LOW     = 2'b01,
    MODE_RUN     = 2'b10
  } mode_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [13:0]   val_q, val_d;
  logic          disp_q, disp_d;
  mode_e         mode_q, mode_d;

  logic          sw_hold, half_tick, sec_tick, btn_any;
  logic [13:0]   dec_val;
  logic [14:0]   add_amt, sum;

  always_comb begin
    sw_hold   = sw0 | sw1;
    // Switches freeze the prescaler at 0, so no tick can fire while held.
    half_tick = !sw_hold && (cnt_q == CNT_LAST);
    sec_tick  = half_tick && phase_q;
    cnt_d     = (sw_hold || half_tick) ? '0 : cnt_q + 1'b1;
    phase_d   = sw_hold ? 1'b0 : (phase_q ^ half_tick);

    // A tick coincident with a button add is folded in, not dropped.
    dec_val   = (sec_tick && (val_q != 14'd0)) ? val_q - 14'd1 : val_q;

    btn_any   = pulse_btnu | pulse_btnl | pulse_btnr | pulse_btnd;
    add_amt   = 15'd0;
    if      (pulse_btnu) add_amt = 15'd30;
    else if (pulse_btnl) add_amt = 15'd120;
    else if (pulse_btnr) add_amt = 15'd180;
    else if (pulse_btnd) add_amt = 15'd300;
    sum       = {1'b0, dec_val} + add_amt;

    val_d = dec_val;
    if      (sw0)     val_d = 14'd15;
    else if (sw1)     val_d = 14'd185;
    else if (btn_any) val_d = (sum > 15'(MAX_TIME)) ? 14'(MAX_TIME) : sum[13:0];

    // Mode follows the value being registered this cycle.
    if (val_d == 14'd0)                  mode_d = MODE_EXPIRED;
    else if (val_d < 14'(LOW_THRESH))    mode_d = MODE_LOW;
    else                                 mode_d = MODE_RUN;

    disp_d = disp_q;
    if (mode_d != mode_q) disp_d = 1'b1;
    else begin
      case (mode_d)
        MODE_LOW:     if (sec_tick)  disp_d = ~disp_q;
        MODE_EXPIRED: if (half_tick) disp_d = ~disp_q;
        default:      disp_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      val_q   <= 14'd0;
      mode_q  <= MODE_EXPIRED;
      disp_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      disp_q  <= disp_d;
    end
  end

  assign time_out = val_q;
  assign disp_on  = disp_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_meter_ctrl.sv
module tb_meter_ctrl;
  localparam int H = 4;

  logic        clk, clr_n;
  logic        pulse_btnu, pulse_btnl, pulse_btnr, pulse_btnd, sw0, sw1;
  logic [13:0] time_out;
  logic        disp_on;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_err    = 0;

  meter_ctrl #(.HALF_SEC_CYCLES(H), .MAX_TIME(9999), .LOW_THRESH(200)) dut (
    .clk(clk), .clr_n(clr_n),
    .pulse_btnu(pulse_btnu), .pulse_btnl(pulse_btnl),
    .pulse_btnr(pulse_btnr), .pulse_btnd(pulse_btnd),
    .sw0(sw0), .sw1(sw1),
    .time_out(time_out), .disp_on(disp_on), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles elapsed since the prescaler last restarted determine ticks.
  int m_n, m_val, m_mode;
  bit m_disp;

  function automatic int mode_of(input int v);
    if (v == 0) return 0;
    if (v < 200) return 1;
    return 2;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    bit half, sec;
    int d, add, nv, nm;
    if (!clr_n) begin
      m_n = 0; m_val = 0; m_mode = 0; m_disp = 1;
    end else begin
      if (sw0 || sw1) begin
        half = 0; sec = 0; m_n = 0;
      end else begin
        half = ((m_n + 1) % H) == 0;
        sec  = ((m_n + 1) % (2 * H)) == 0;
        m_n  = m_n + 1;
      end
      if (sw0)      nv = 15;
      else if (sw1) nv = 185;
      else begin
        d   = (sec && m_val > 0) ? m_val - 1 : m_val;
        add = pulse_btnu ? 30 : pulse_btnl ? 120 : pulse_btnr ? 180 : pulse_btnd ? 300 : 0;
        nv  = (add != 0) ? ((d + add > 9999) ? 9999 : d + add) : d;
      end
      nm = mode_of(nv);
      if (nm != m_mode)  m_disp = 1;
      else if (nm == 2)  m_disp = 1;
      else if (nm == 1)  m_disp = sec ? ~m_disp : m_disp;
      else               m_disp = half ? ~m_disp : m_disp;
      m_val  = nv;
      m_mode = nm;
    end
  end

  always @(negedge clk) begin
    check("model_time_out", time_out, m_val);
    check("model_mode", mode, m_mode);
    check("model_disp_on", disp_on, m_disp);
  end

  task automatic wait_val(input int v, input int budget, input string name);
    int i;
    for (i = 0; i < budget && time_out != v; i++) @(negedge clk);
    if (time_out != v) begin
      n_checks++; n_err++;
      $display("FAIL %s: timeout waiting for time_out=%0d, got %0d", name, v, time_out);
    end
  endtask

  initial begin
    clk = 0; clr_n = 0;
    pulse_btnu = 0; pulse_btnl = 0; pulse_btnr = 0; pulse_btnd = 0; sw0 = 0; sw1 = 0;
    #12;
    check("rst_time_out", time_out, 0);
    check("rst_mode", mode, 0);
    check("rst_disp_on", disp_on, 1);
    @(negedge clk) clr_n = 1;

    // Idle expired blink: first half-tick lands at the 4th edge.
    repeat (3) @(negedge clk);
    check("blink_first_on", disp_on, 1);
    @(negedge clk);
    check("blink_first_off", disp_on, 0);
    repeat (36) @(negedge clk);
    check("idle_time_out", time_out, 0);
    check("idle_mode", mode, 0);

    // btnu from 0
    pulse_btnu = 1;
    @(negedge clk) pulse_btnu = 0;
    check("btnu_val", time_out, 30);
    check("btnu_mode", mode, 1);
    check("btnu_disp", disp_on, 1);
    repeat (10) @(negedge clk);

    // Priority: sw0 beats sw1 and buttons
    sw0 = 1; sw1 = 1; pulse_btnu = 1;
    @(negedge clk) begin sw0 = 0; pulse_btnu = 0; end
    check("sw0_prio", time_out, 15);
    for (int i = 0; i < 20; i++) begin
      pulse_btnd = (i == 5);
      @(negedge clk);
      check("sw1_hold", time_out, 185);
    end
    check("sw1_mode", mode, 1);
    sw1 = 0;
    repeat (7) @(negedge clk);
    check("sw1_release_pre", time_out, 185);
    @(negedge clk);
    check("sw1_release_dec", time_out, 184);

    // btnr from 185 on the release cycle
    sw1 = 1;
    @(negedge clk) begin sw1 = 0; pulse_btnr = 1; end
    @(negedge clk) pulse_btnr = 0;
    check("btnr_val", time_out, 365);
    check("btnr_mode", mode, 2);
    check("btnr_disp", disp_on, 1);
    wait_val(199, 2000, "wait_199");
    check("low_entry_mode", mode, 1);
    check("low_entry_disp", disp_on, 1);

    // Simultaneous btnd+btnu from 100: btnu wins
    wait_val(100, 1000, "wait_100a");
    pulse_btnd = 1; pulse_btnu = 1;
    @(negedge clk) begin pulse_btnd = 0; pulse_btnu = 0; end
    check("dual_btn", time_out, 130);
    wait_val(100, 400, "wait_100b");
    // next sec_tick is 8 cycles after the previous decrement
    repeat (7) @(negedge clk);
    pulse_btnd = 1;
    @(negedge clk) pulse_btnd = 0;
    check("btnd_tick", time_out, 399);

    // Saturation
    pulse_btnd = 1;
    repeat (40) @(negedge clk);
    pulse_btnd = 0;
    check("sat_val", time_out, 9999);
    check("sat_mode", mode, 2);
    wait_val(9998, 20, "sat_dec");
    check("sat_dec_val", time_out, 9998);

    // Mid-cycle async reset
    repeat (3) @(negedge clk);
    #2 clr_n = 0;
    #1;
    check("async_time_out", time_out, 0);
    check("async_mode", mode, 0);
    check("async_disp", disp_on, 1);
    @(negedge clk) clr_n = 1;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
